// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: architectural flag register, condition-code squash and a
// 2-entry skid FIFO presenting results to register-file writeback via valid/ready.
module alu_writeback_stage #(
  parameter int unsigned N     = 19,
  parameter int unsigned REG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_result,
  input  logic [2:0]       in_flags,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_regwrite,
  input  logic             in_flagwrite,
  input  logic [2:0]       in_cond,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [N-1:0]     wb_result,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_regwrite,
  output logic             wb_executed,
  output logic [2:0]       flags_q
);

  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0][N-1:0]     res_q, res_d;
  logic [1:0][REG_W-1:0] rd_q, rd_d;
  logic [1:0]            rw_q, rw_d;
  logic [1:0]            ex_q, ex_d;
  logic [2:0]            flags_d;

  logic cond_pass;
  logic push, pop;
  logic flag_z, flag_o, flag_n;

  assign flag_z = flags_q[2];
  assign flag_o = flags_q[1];
  assign flag_n = flags_q[0];

  // Evaluated on the flag register as it stands before this cycle's update.
  always_comb begin
    cond_pass = 1'b1;
    case (in_cond)
      3'b000:  cond_pass = 1'b1;
      3'b001:  cond_pass = flag_z;
      3'b010:  cond_pass = !flag_z;
      3'b011:  cond_pass = flag_n ^ flag_o;
      3'b100:  cond_pass = !(flag_n ^ flag_o);
      3'b101:  cond_pass = !flag_z && !(flag_n ^ flag_o);
      3'b110:  cond_pass = flag_z || (flag_n ^ flag_o);
      3'b111:  cond_pass = flag_o;
      default: cond_pass = 1'b1;
    endcase
  end

  assign in_ready = (count_q != 2'd2);
  assign wb_valid = (count_q != 2'd0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = wb_valid && wb_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    res_d    = res_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    ex_d     = ex_q;
    flags_d  = flags_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        res_d[wr_ptr_q] = in_result;
        rd_d[wr_ptr_q]  = in_rd;
        rw_d[wr_ptr_q]  = in_regwrite && cond_pass;
        ex_d[wr_ptr_q]  = cond_pass;
        wr_ptr_d        = !wr_ptr_q;
        if (in_flagwrite && cond_pass) begin
          flags_d = in_flags;
        end
      end
      if (pop) begin
        rd_ptr_d = !rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      res_q    <= '0;
      rd_q     <= '0;
      rw_q     <= '0;
      ex_q     <= '0;
      flags_q  <= 3'b000;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      ex_q     <= ex_d;
      flags_q  <= flags_d;
    end
  end

  // Payload reads as zero whenever no head entry is present.
  assign wb_result   = wb_valid ? res_q[rd_ptr_q] : '0;
  assign wb_rd       = wb_valid ? rd_q[rd_ptr_q]  : '0;
  assign wb_regwrite = wb_valid && rw_q[rd_ptr_q];
  assign wb_executed = wb_valid && ex_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed vector table for the documented scenarios,
// then random traffic compared against a queue-based reference model.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [18:0] in_result;
  logic [2:0]  in_flags;
  logic [3:0]  in_rd;
  logic        in_regwrite, in_flagwrite;
  logic [2:0]  in_cond;
  logic        flush, wb_valid, wb_ready;
  logic [18:0] wb_result;
  logic [3:0]  wb_rd;
  logic        wb_regwrite, wb_executed;
  logic [2:0]  flags_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_writeback_stage #(.N(19), .REG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_flagwrite(in_flagwrite), .in_cond(in_cond),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_executed(wb_executed),
    .flags_q(flags_q)
  );

  typedef struct {
    logic rst; logic vld; logic [18:0] res; logic [2:0] fl; logic [3:0] rd;
    logic rw; logic fw; logic [2:0] cond; logic fls; logic rdy;
    logic e_v; logic e_r; logic [18:0] e_res; logic [3:0] e_rd;
    logic e_rw; logic e_ex; logic [2:0] e_fl;
  } vec_t;

  typedef struct { logic [18:0] res; logic [3:0] rd; logic rw; logic ex; } ent_t;

  ent_t       mq[$];
  logic [2:0] mflags = 3'b000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit z, o, n;
    z = f[2]; o = f[1]; n = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != o;
      3'd4: return n == o;
      3'd5: return !z && (n == o);
      3'd6: return z || (n != o);
      default: return o;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit can_push, can_pop, ok;
    ent_t e;
    if (reset) begin
      mq.delete();
      mflags = 3'b000;
      return;
    end
    if (flush) begin
      mq.delete();
      return;
    end
    can_push = in_valid && (mq.size() < 2);
    can_pop  = wb_ready && (mq.size() > 0);
    ok = cond_ok(in_cond, mflags);
    if (can_pop) void'(mq.pop_front());
    if (can_push) begin
      e.res = in_result; e.rd = in_rd; e.rw = in_regwrite && ok; e.ex = ok;
      mq.push_back(e);
      if (in_flagwrite && ok) mflags = in_flags;
    end
  endtask

  task automatic check_model();
    chk("model wb_valid", 32'(wb_valid), 32'(mq.size() != 0));
    chk("model in_ready", 32'(in_ready), 32'(mq.size() != 2));
    chk("model flags_q", 32'(flags_q), 32'(mflags));
    if (mq.size() != 0) begin
      chk("model wb_result", 32'(wb_result), 32'(mq[0].res));
      chk("model wb_rd", 32'(wb_rd), 32'(mq[0].rd));
      chk("model wb_regwrite", 32'(wb_regwrite), 32'(mq[0].rw));
      chk("model wb_executed", 32'(wb_executed), 32'(mq[0].ex));
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; in_valid = v.vld; in_result = v.res; in_flags = v.fl; in_rd = v.rd;
    in_regwrite = v.rw; in_flagwrite = v.fw; in_cond = v.cond; flush = v.fls;
    wb_ready = v.rdy;
  endtask

  vec_t vecs[$];

  initial begin
    // rst vld res fl rd rw fw cond fls rdy | e_v e_r e_res e_rd e_rw e_ex e_fl
    vecs.push_back('{1, 0, 19'h0,   3'b000, 4'd0, 0, 0, 3'd0, 0, 0, 0, 1, 19'h0,   4'd0, 0, 0, 3'b000});
    vecs.push_back('{0, 1, 19'h5,   3'b000, 4'd3, 1, 1, 3'd0, 0, 0, 1, 1, 19'h5,   4'd3, 1, 1, 3'b000});
    vecs.push_back('{0, 0, 19'h0,   3'b000, 4'd0, 0, 0, 3'd0, 0, 1, 0, 1, 19'h0,   4'd0, 0, 0, 3'b000});
    vecs.push_back('{0, 1, 19'h7,   3'b100, 4'd1, 1, 1, 3'd0, 0, 1, 1, 1, 19'h7,   4'd1, 1, 1, 3'b100});
    vecs.push_back('{0, 1, 19'h9,   3'b000, 4'd2, 1, 0, 3'd1, 0, 1, 1, 1, 19'h9,   4'd2, 1, 1, 3'b100});
    vecs.push_back('{0, 1, 19'hB,   3'b000, 4'd4, 1, 0, 3'd2, 0, 1, 1, 1, 19'hB,   4'd4, 0, 0, 3'b100});
    vecs.push_back('{0, 0, 19'h0,   3'b000, 4'd0, 0, 0, 3'd0, 0, 1, 0, 1, 19'h0,   4'd0, 0, 0, 3'b100});
    vecs.push_back('{0, 1, 19'h100, 3'b000, 4'd5, 1, 0, 3'd0, 0, 0, 1, 1, 19'h100, 4'd5, 1, 1, 3'b100});
    vecs.push_back('{0, 1, 19'h200, 3'b000, 4'd6, 1, 0, 3'd0, 0, 0, 1, 0, 19'h100, 4'd5, 1, 1, 3'b100});
    vecs.push_back('{0, 1, 19'h300, 3'b000, 4'd7, 1, 0, 3'd0, 0, 0, 1, 0, 19'h100, 4'd5, 1, 1, 3'b100});
    vecs.push_back('{0, 0, 19'h0,   3'b000, 4'd0, 0, 0, 3'd0, 0, 1, 1, 1, 19'h200, 4'd6, 1, 1, 3'b100});
    vecs.push_back('{0, 0, 19'h0,   3'b000, 4'd0, 0, 0, 3'd0, 0, 1, 0, 1, 19'h0,   4'd0, 0, 0, 3'b100});
    vecs.push_back('{0, 1, 19'h1,   3'b001, 4'd7, 1, 1, 3'd0, 0, 1, 1, 1, 19'h1,   4'd7, 1, 1, 3'b001});
    vecs.push_back('{0, 1, 19'h2,   3'b100, 4'd8, 1, 1, 3'd3, 0, 1, 1, 1, 19'h2,   4'd8, 1, 1, 3'b100});
    vecs.push_back('{0, 1, 19'h3,   3'b011, 4'd9, 1, 1, 3'd3, 0, 1, 1, 1, 19'h3,   4'd9, 0, 0, 3'b100});
    vecs.push_back('{0, 1, 19'hA,   3'b000, 4'd1, 1, 0, 3'd0, 0, 0, 1, 0, 19'h3,   4'd9, 0, 0, 3'b100});
    vecs.push_back('{0, 1, 19'hE,   3'b111, 4'd2, 1, 1, 3'd0, 1, 1, 0, 1, 19'h0,   4'd0, 0, 0, 3'b100});
    vecs.push_back('{0, 1, 19'hB,   3'b010, 4'd3, 1, 1, 3'd0, 1, 0, 0, 1, 19'h0,   4'd0, 0, 0, 3'b100});
    vecs.push_back('{0, 1, 19'hC,   3'b000, 4'd2, 1, 0, 3'd0, 0, 0, 1, 1, 19'hC,   4'd2, 1, 1, 3'b100});
    vecs.push_back('{0, 1, 19'hD,   3'b000, 4'd3, 1, 0, 3'd0, 0, 0, 1, 0, 19'hC,   4'd2, 1, 1, 3'b100});
    vecs.push_back('{1, 1, 19'hF,   3'b111, 4'd4, 1, 1, 3'd0, 0, 0, 0, 1, 19'h0,   4'd0, 0, 0, 3'b000});

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_r));
      chk($sformatf("vec%0d flags_q", i), 32'(flags_q), 32'(vecs[i].e_fl));
      if (vecs[i].e_v || vecs[i].rst) begin
        chk($sformatf("vec%0d wb_result", i), 32'(wb_result), 32'(vecs[i].e_res));
        chk($sformatf("vec%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
        chk($sformatf("vec%0d wb_regwrite", i), 32'(wb_regwrite), 32'(vecs[i].e_rw));
        chk($sformatf("vec%0d wb_executed", i), 32'(wb_executed), 32'(vecs[i].e_ex));
      end
      check_model();
    end

    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      wb_ready     = ($urandom_range(0, 2) != 0);
      in_result    = 19'($urandom);
      in_flags     = 3'($urandom);
      in_rd        = 4'($urandom);
      in_regwrite  = 1'($urandom);
      in_flagwrite = ($urandom_range(0, 1) == 0);
      in_cond      = 3'($urandom);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
